mips_cpu_muldiv: RTL and testbench

MIPS_CPU_MULDIV -- requirements
Module: mips_cpu_muldiv

---
 rtl/mips_cpu_muldiv.sv | 174 +++++++++++++++++
 tb/tb_mips_cpu_muldiv.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/mips_cpu_muldiv.sv
// mips_cpu_muldiv: HI/LO multiply/divide unit for a MIPS-style core.
// Iterative shift-add multiply and restoring divide, BITS_PER_CYCLE bits per
// CALC cycle. Define MIPS_CPU_MULDIV_FAST_MUL_EN for a single-cycle multiplier.
//
// state | meaning
// IDLE  | waiting for start; MTHI/MTLO write hi/lo directly
// CALC  | iterating on captured operand magnitudes, hi/lo held
// DONE  | new result in hi/lo, done pulse for one cycle
module mips_cpu_muldiv #(
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] op1,
  input  logic [31:0] op2,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int N = 32 / BITS_PER_CYCLE;
  localparam int CW = 5;
  localparam logic [CW-1:0] CNT_INIT = CW'(N - 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          is_div_q, is_div_d;
  logic          sign_a_q, sign_a_d;
  logic          sign_b_q, sign_b_d;
  logic [31:0]   mag_a_q, mag_a_d;
  logic [31:0]   mag_b_q, mag_b_d;
  // Mul: {upper partial sum (33b), multiplier shifting out}.
  // Div: {remainder (33b), dividend shifting out / quotient shifting in}.
  logic [64:0]   acc_q, acc_d;
  logic [31:0]   hi_q, hi_d;
  logic [31:0]   lo_q, lo_d;

  logic [64:0]   acc_step;
  logic [64:0]   shifted;
  logic [33:0]   trial;
  logic [32:0]   sum;
  logic [63:0]   mul_mag;
  logic [63:0]   mul_res;
  logic [31:0]   div_q;
  logic [31:0]   div_r;
  logic          last;
  logic          signed_op;

  // One CALC cycle worth of iterations on the accumulator.
  always_comb begin
    acc_step = acc_q;
    shifted  = '0;
    trial    = '0;
    sum      = '0;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      if (is_div_q) begin
        shifted = {acc_step[63:0], 1'b0};
        trial   = {1'b0, shifted[64:32]} - {2'b00, mag_b_q};
        if (!trial[33]) acc_step = {trial[32:0], shifted[31:1], 1'b1};
        else            acc_step = shifted;
      end else begin
        sum      = acc_step[64:32] + (acc_step[0] ? {1'b0, mag_b_q} : 33'd0);
        acc_step = {1'b0, sum, acc_step[31:1]};
      end
    end
  end

  // Signed fix-up of the magnitude results and end-of-CALC detection.
  always_comb begin
`ifdef MIPS_CPU_MULDIV_FAST_MUL_EN
    mul_mag = 64'(mag_a_q) * 64'(mag_b_q);
    last    = !is_div_q || (cnt_q == '0);
`else
    mul_mag = acc_step[63:0];
    last    = (cnt_q == '0);
`endif
    mul_res = (sign_a_q ^ sign_b_q) ? -mul_mag : mul_mag;
    div_q   = (sign_a_q ^ sign_b_q) ? -acc_step[31:0] : acc_step[31:0];
    div_r   = sign_a_q ? -acc_step[63:32] : acc_step[63:32];
  end

  // Next-state, operand capture and hi/lo update.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    is_div_d  = is_div_q;
    sign_a_d  = sign_a_q;
    sign_b_d  = sign_b_q;
    mag_a_d   = mag_a_q;
    mag_b_d   = mag_b_q;
    acc_d     = acc_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    signed_op = ~op[0];
    case (state_q)
      IDLE: begin
        if (start) begin
          if (op[2] == 1'b0) begin
            is_div_d = op[1];
            sign_a_d = signed_op & op1[31];
            sign_b_d = signed_op & op2[31];
            mag_a_d  = (signed_op & op1[31]) ? -op1 : op1;
            mag_b_d  = (signed_op & op2[31]) ? -op2 : op2;
            acc_d    = {33'd0, ((signed_op & op1[31]) ? -op1 : op1)};
            cnt_d    = CNT_INIT;
            state_d  = CALC;
          end else if (op == 3'b100) begin
            hi_d = op1;
          end else if (op == 3'b101) begin
            lo_d = op1;
          end
        end
      end
      CALC: begin
        acc_d = acc_step;
        if (last) begin
          state_d = DONE;
          if (!is_div_q) begin
            {hi_d, lo_d} = mul_res;
          end else if (mag_b_q == '0) begin
            // Divide by zero: hand back the dividend, all-ones quotient.
            hi_d = sign_a_q ? -mag_a_q : mag_a_q;
            lo_d = 32'hFFFF_FFFF;
          end else begin
            hi_d = div_r;
            lo_d = div_q;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      is_div_q <= 1'b0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      mag_a_q  <= '0;
      mag_b_q  <= '0;
      acc_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      is_div_q <= is_div_d;
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
      mag_a_q  <= mag_a_d;
      mag_b_q  <= mag_b_d;
      acc_q    <= acc_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  assign busy = (state_q == CALC);
  assign done = (state_q == DONE);
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mips_cpu_muldiv.sv
// Testbench for mips_cpu_muldiv: directed and random ops against an
// arithmetic reference model. Honours MIPS_CPU_MULDIV_FAST_MUL_EN.
module tb_mips_cpu_muldiv;

  localparam int BPC = 1;
  localparam int N   = 32 / BPC;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [2:0]  op;
  logic [31:0] op1;
  logic [31:0] op2;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int          n_checks;
  int          n_pass;
  logic [31:0] hi_m;
  logic [31:0] lo_m;

  mips_cpu_muldiv #(.BITS_PER_CYCLE(BPC)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .op1(op1), .op2(op2),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Reference: plain 64-bit arithmetic on the architectural operands.
  task automatic model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] eh, output logic [31:0] el);
    longint      sa, sb, sq, sr;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    eh = hi_m;
    el = lo_m;
    case (o)
      3'b000: begin p = 64'(sa * sb); eh = p[63:32]; el = p[31:0]; end
      3'b001: begin p = {32'd0, a} * {32'd0, b}; eh = p[63:32]; el = p[31:0]; end
      3'b010: begin
        if (b == 0) begin eh = a; el = 32'hFFFF_FFFF; end
        else begin
          sq = sa / sb; sr = sa % sb;
          el = sq[31:0]; eh = sr[31:0];
        end
      end
      3'b011: begin
        if (b == 0) begin eh = a; el = 32'hFFFF_FFFF; end
        else begin el = a / b; eh = a % b; end
      end
      default: ;
    endcase
  endtask

  function automatic int exp_latency(input logic [2:0] o);
`ifdef MIPS_CPU_MULDIV_FAST_MUL_EN
    if (o[1] == 1'b0) return 2;
`endif
    return N + 1;
  endfunction

  // Issue a MULT/DIV op; inj>0 pulses a competing DIV 1/1 start in that cycle.
  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        input int inj, input string tag);
    logic [31:0] eh, el;
    int          cyc;
    logic        hold_ok;
    model(o, a, b, eh, el);
    @(negedge clk);
    start = 1'b1; op = o; op1 = a; op2 = b;
    @(posedge clk); #1;
    start = 1'b0; op = 3'($urandom_range(0, 3)); op1 = $urandom; op2 = $urandom;
    cyc = 1;
    hold_ok = 1'b1;
    while (done !== 1'b1 && cyc < 200) begin
      if (busy !== 1'b1 || hi !== hi_m || lo !== lo_m) hold_ok = 1'b0;
      if (cyc == inj) begin start = 1'b1; op = 3'b010; op1 = 32'd1; op2 = 32'd1; end
      else start = 1'b0;
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0;
    check({tag, "_latency"}, 32'(cyc), 32'(exp_latency(o)));
    check({tag, "_hold"}, {31'd0, hold_ok}, 32'd1);
    check({tag, "_hi"}, hi, eh);
    check({tag, "_lo"}, lo, el);
    check({tag, "_busy_in_done"}, {31'd0, busy}, 32'd0);
    hi_m = eh;
    lo_m = el;
    @(posedge clk); #1;
    check({tag, "_done_single"}, {30'd0, busy, done}, 32'd0);
  endtask

  task automatic run_mt(input logic [2:0] o, input logic [31:0] a, input string tag);
    @(negedge clk);
    start = 1'b1; op = o; op1 = a;
    @(posedge clk); #1;
    start = 1'b0;
    if (o == 3'b100) hi_m = a;
    if (o == 3'b101) lo_m = a;
    check({tag, "_hi"}, hi, hi_m);
    check({tag, "_lo"}, lo, lo_m);
    check({tag, "_busy_done"}, {30'd0, busy, done}, 32'd0);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'h8000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'($urandom_range(0, 3));
      3:       return 32'($urandom_range(0, 200));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int npulse;
    n_checks = 0; n_pass = 0;
    hi_m = '0; lo_m = '0;
    rst_n = 1'b0; start = 1'b0; op = '0; op1 = '0; op2 = '0;
    #12;
    check("reset_hi", hi, 32'd0);
    check("reset_lo", lo, 32'd0);
    check("reset_busy_done", {30'd0, busy, done}, 32'd0);

    // First start accepted on the first edge after release.
    @(negedge clk);
    rst_n = 1'b1; start = 1'b1; op = 3'b100; op1 = 32'hCAFE_0001;
    @(posedge clk); #1;
    start = 1'b0;
    hi_m = 32'hCAFE_0001;
    check("first_mthi_hi", hi, hi_m);

    run_op(3'b000, 32'hFFFF_FFFE, 32'd3, 0, "mult_neg2x3");
    run_op(3'b010, 32'hFFFF_FFF9, 32'd2, 0, "div_m7_2");
    run_op(3'b011, 32'd5, 32'd0, 0, "divu_by0");
    run_op(3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 0, "div_ovf");
    run_op(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, "multu_max");
    run_op(3'b011, 32'd100, 32'd7, 5, "divu_ignore");
    repeat (3) begin
      @(posedge clk); #1;
      check("after_ignore_idle", {30'd0, busy, done}, 32'd0);
    end

    run_mt(3'b101, 32'h0000_1234, "mtlo");
    run_mt(3'b100, 32'h5555_AAAA, "mthi");
    run_mt(3'b110, 32'hDEAD_BEEF, "noop");

    // Mid-cycle asynchronous reset in the middle of a divide.
    @(negedge clk);
    start = 1'b1; op = 3'b011; op1 = 32'd1000; op2 = 32'd3;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    #2 rst_n = 1'b0;
    #1;
    check("abort_hi", hi, 32'd0);
    check("abort_lo", lo, 32'd0);
    check("abort_busy_done", {30'd0, busy, done}, 32'd0);
    hi_m = '0; lo_m = '0;
    @(negedge clk); rst_n = 1'b1;
    npulse = 0;
    repeat (N + 8) begin
      @(posedge clk); #1;
      if (done === 1'b1 || busy === 1'b1) npulse++;
    end
    check("abort_no_result", 32'(npulse), 32'd0);
    check("abort_hilo_zero", hi | lo, 32'd0);

    for (int k = 0; k < 24; k++) begin
      logic [2:0] ro;
      ro = 3'($urandom_range(0, 3));
      if ($urandom_range(0, 4) == 0) run_mt(3'($urandom_range(4, 5)), $urandom, "rand_mt");
      run_op(ro, pick(), pick(), 0, "rand_op");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
